// File: rtl/div_16x8.sv
// div_16x8: 16-bit by 8-bit iterative restoring divider with valid/ready handshakes.
//
// Ports:
//   clk        single clock, all state on the rising edge
//   rst        synchronous active-high reset
//   in_valid   dividend/divisor presented        in_ready   idle, can accept
//   A [15:0]   dividend                          B [7:0]    divisor
//   out_valid  result held valid                 out_ready  consumer takes result
//   Q [15:0]   quotient                          R [7:0]    remainder
//   dz         divide-by-zero flag               ovf        quotient overflow flag
//
// SIGNED=1 treats A/B as two's complement (truncating division, R takes the sign
// of A); SIGNED=0 treats them as unsigned. Latency is 16 divide steps plus one
// sign-fix cycle; a zero divisor goes straight to DONE.
module div_16x8 #(
  parameter int unsigned SIGNED = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [7:0]  B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Q,
  output logic [7:0]  R,
  output logic        dz,
  output logic        ovf
);

  localparam bit IsSigned = (SIGNED != 0);

  typedef enum logic [1:0] {StIdle, StDiv, StFix, StDone} state_e;

  state_e      state_q;
  logic [15:0] quo_q;    // dividend bits shift out at the top, quotient bits shift in
  logic [7:0]  rem_q;    // partial remainder, always < divisor magnitude
  logic [7:0]  dvs_q;    // divisor magnitude (128 fits for B = 8'h80)
  logic [3:0]  cnt_q;
  logic        q_neg_q;
  logic        r_neg_q;

  logic        a_neg, b_neg;
  logic [15:0] a_mag;
  logic [7:0]  b_mag;
  logic [8:0]  shifted;
  logic [7:0]  diff;
  logic        take;
  logic [7:0]  rem_next;
  logic [15:0] quo_next;
  logic [15:0] q_fix;
  logic [7:0]  r_fix;
  logic        q_over;

  always_comb begin
    a_neg = IsSigned && A[15];
    b_neg = IsSigned && B[7];
    a_mag = a_neg ? (~A + 16'd1) : A;
    b_mag = b_neg ? (~B + 8'd1) : B;

    // 9-bit trial: remainder can reach 2*|B|-1 = 255 before the compare.
    shifted  = {rem_q, quo_q[15]};
    take     = (shifted >= {1'b0, dvs_q});
    // When take is set the true difference is < 256, so 8 bits are exact.
    diff     = shifted[7:0] - dvs_q;
    rem_next = take ? diff : shifted[7:0];
    quo_next = {quo_q[14:0], take};

    // Only -32768 / -1 yields a positive magnitude of 32768.
    q_over = IsSigned && !q_neg_q && quo_q[15];
    q_fix  = q_neg_q ? (~quo_q + 16'd1) : quo_q;
    r_fix  = r_neg_q ? (~rem_q + 8'd1) : rem_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Q         <= '0;
      R         <= '0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (B == 8'd0) begin
              Q         <= 16'hFFFF;
              R         <= A[7:0];
              dz        <= 1'b1;
              ovf       <= 1'b0;
              out_valid <= 1'b1;
              state_q   <= StDone;
            end else begin
              quo_q   <= a_mag;
              dvs_q   <= b_mag;
              rem_q   <= '0;
              cnt_q   <= '0;
              q_neg_q <= a_neg ^ b_neg;
              r_neg_q <= a_neg;
              state_q <= StDiv;
            end
          end
        end
        StDiv: begin
          quo_q <= quo_next;
          rem_q <= rem_next;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          Q         <= q_over ? 16'h7FFF : q_fix;
          R         <= r_fix;
          dz        <= 1'b0;
          ovf       <= q_over;
          out_valid <= 1'b1;
          state_q   <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_16x8.sv
// tb_div_16x8: drives a signed and an unsigned div_16x8 with identical stimulus.
// Each issued operation pushes its expected result (hand-computed or from a
// reference model) into a per-instance queue; a monitor pops and compares when
// the instance raises out_valid, including the accept-to-valid latency.
module tb_div_16x8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a_in;
  logic [7:0]  b_in;
  logic        out_ready;

  logic        ir_s, ov_s, dz_s, of_s;
  logic [15:0] q_s;
  logic [7:0]  r_s;
  logic        ir_u, ov_u, dz_u, of_u;
  logic [15:0] q_u;
  logic [7:0]  r_u;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    logic        ovf;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_s[$];
  exp_t sb_u[$];

  div_16x8 #(.SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_s), .A(a_in), .B(b_in),
    .out_valid(ov_s), .out_ready(out_ready), .Q(q_s), .R(r_s), .dz(dz_s), .ovf(of_s)
  );

  div_16x8 #(.SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_u), .A(a_in), .B(b_in),
    .out_valid(ov_u), .out_ready(out_ready), .Q(q_u), .R(r_u), .dz(dz_u), .ovf(of_u)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] q, input logic [7:0] r, input logic dz,
                              input logic ovf);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.ovf = ovf; e.acc = 0;
    e.lat = dz ? 1 : 18;
    return e;
  endfunction

  // Reference: SV integer division truncates toward zero, % takes the dividend sign.
  function automatic exp_t model(input bit sgn, input logic [15:0] a, input logic [7:0] b);
    exp_t e;
    int sa, sb, qi, ri;
    e.dz = 1'b0; e.ovf = 1'b0; e.lat = 18; e.acc = 0;
    if (b == 8'd0) begin
      e.q = 16'hFFFF; e.r = a[7:0]; e.dz = 1'b1; e.lat = 1;
    end else if (!sgn) begin
      e.q = a / {8'd0, b};
      e.r = 8'(a % {8'd0, b});
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      qi = sa / sb;
      ri = sa % sb;
      if (qi > 32767) begin
        qi = 32767;
        e.ovf = 1'b1;
      end
      e.q = qi[15:0];
      e.r = ri[7:0];
    end
    return e;
  endfunction

  // Called #1 after an edge; returns #1 after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [7:0] b, input exp_t es,
                       input exp_t eu);
    int t = 0;
    while (!(ir_s && ir_u) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) begin
      chk("issue_timeout", 32'd1, 32'd0);
      return;
    end
    a_in = a; b_in = b; in_valid = 1'b1;
    es.acc = cyc + 1;
    eu.acc = cyc + 1;
    sb_s.push_back(es);
    sb_u.push_back(eu);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb_s.size() != 0 || sb_u.size() != 0) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  // Monitor
  initial begin
    bit          seen [2];
    logic        ov, dzv, ofv;
    logic [15:0] qv;
    logic [7:0]  rv;
    int          qn;
    exp_t        e;
    seen[0] = 1'b0; seen[1] = 1'b0;
    forever begin
      @(posedge clk); #2;
      for (int k = 0; k < 2; k++) begin
        ov  = (k == 0) ? ov_s : ov_u;
        qv  = (k == 0) ? q_s  : q_u;
        rv  = (k == 0) ? r_s  : r_u;
        dzv = (k == 0) ? dz_s : dz_u;
        ofv = (k == 0) ? of_s : of_u;
        qn  = (k == 0) ? sb_s.size() : sb_u.size();
        if (ov && !seen[k]) begin
          seen[k] = 1'b1;
          if (qn == 0) begin
            chk($sformatf("dut%0d_unexpected_out_valid", k), 32'd1, 32'd0);
          end else begin
            e = (k == 0) ? sb_s.pop_front() : sb_u.pop_front();
            chk($sformatf("dut%0d_q", k), 32'(qv), 32'(e.q));
            chk($sformatf("dut%0d_r", k), 32'(rv), 32'(e.r));
            chk($sformatf("dut%0d_dz", k), 32'(dzv), 32'(e.dz));
            chk($sformatf("dut%0d_ovf", k), 32'(ofv), 32'(e.ovf));
            chk($sformatf("dut%0d_latency", k), 32'(cyc - e.acc + 1), 32'(e.lat));
          end
        end else if (!ov) begin
          seen[k] = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    int          bad;

    rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready_s", 32'(ir_s), 32'd1);  chk("rst_in_ready_u", 32'(ir_u), 32'd1);
    chk("rst_out_valid_s", 32'(ov_s), 32'd0); chk("rst_out_valid_u", 32'(ov_u), 32'd0);
    chk("rst_q_s", 32'(q_s), 32'd0);          chk("rst_q_u", 32'(q_u), 32'd0);
    chk("rst_r_s", 32'(r_s), 32'd0);          chk("rst_r_u", 32'(r_u), 32'd0);
    chk("rst_dz_s", 32'(dz_s), 32'd0);        chk("rst_ovf_s", 32'(of_s), 32'd0);
    rst = 1'b0;

    // Directed: first one is accepted on the first edge after reset release.
    issue(16'h03E8, 8'h07, mk(16'h008E, 8'h06, 0, 0), mk(16'h008E, 8'h06, 0, 0));
    issue(16'hFC18, 8'h07, mk(16'hFF72, 8'hFA, 0, 0), mk(16'h2403, 8'h03, 0, 0));
    issue(16'hFFFF, 8'hFF, mk(16'h0001, 8'h00, 0, 0), mk(16'h0101, 8'h00, 0, 0));
    issue(16'h1234, 8'h00, mk(16'hFFFF, 8'h34, 1, 0), mk(16'hFFFF, 8'h34, 1, 0));
    issue(16'h8000, 8'hFF, mk(16'h7FFF, 8'h00, 0, 1), mk(16'h0080, 8'h80, 0, 0));
    issue(16'h7FFF, 8'h80, mk(16'hFF01, 8'h7F, 0, 0), mk(16'h00FF, 8'h7F, 0, 0));
    issue(16'h0000, 8'h05, mk(16'h0000, 8'h00, 0, 0), mk(16'h0000, 8'h00, 0, 0));
    issue(16'h8000, 8'h01, mk(16'h8000, 8'h00, 0, 0), mk(16'h8000, 8'h00, 0, 0));
    issue(16'hF000, 8'h80, mk(16'h0020, 8'h00, 0, 0), mk(16'h01E0, 8'h00, 0, 0));
    issue(16'hFFF9, 8'h02, mk(16'hFFFD, 8'hFF, 0, 0), mk(16'h7FFC, 8'h01, 0, 0));
    drain();

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    issue(16'h03E8, 8'h07, mk(16'h008E, 8'h06, 0, 0), mk(16'h008E, 8'h06, 0, 0));
    bad = 0;
    while (!ov_s && bad < 40) begin
      @(posedge clk); #1;
      bad++;
    end
    chk("bp_valid_seen", 32'(ov_s), 32'd1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(ov_s), 32'd1);
      chk("bp_hold_q", 32'(q_s), 32'h008E);
      chk("bp_hold_r", 32'(r_u), 32'h06);
      chk("bp_hold_in_ready", 32'(ir_s), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(ov_s), 32'd0);
    chk("bp_release_in_ready", 32'(ir_s), 32'd1);
    drain();

    // Reset mid-operation: aborted op must never produce a result.
    issue(16'h03E8, 8'h07, mk(16'h008E, 8'h06, 0, 0), mk(16'h008E, 8'h06, 0, 0));
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_out_valid", 32'(ov_s), 32'd0);
    chk("abort_in_ready", 32'(ir_s), 32'd1);
    chk("abort_q", 32'(q_s), 32'd0);
    chk("abort_q_u", 32'(q_u), 32'd0);
    rst = 1'b0;
    sb_s.delete();
    sb_u.delete();
    bad = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (ov_s || ov_u) bad++;
    end
    chk("abort_no_result", 32'(bad), 32'd0);

    // Random regression against the reference model, with forced corners.
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rb = 8'($urandom);
      case (i % 10)
        0: rb = 8'h80;
        1: ra = 16'h7FFF;
        2: ra = 16'h0000;
        3: rb = 8'h00;
        4: begin ra = 16'h8000; rb = 8'hFF; end
        default: ;
      endcase
      issue(ra, rb, model(1'b1, ra, rb), model(1'b0, ra, rb));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
